fc_layer_sequencer: RTL
=======================

# fc_layer_sequencer

Sequences one fully-connected layer on a single shared `mac` datapath instance. For each output neuron it streams IN_DIM input/weight pairs through the MAC and chains the running sum back through the MAC's accumulate port. It then adds the bias through the MAC's add path, applies ReLU and requantization, and writes one 8-bit result. It sits between the layer's input, weight and bias buffers and the output activation buffer, and is started by the network-level controller.

## Interface
- IN_DIM, 64, inputs per neuron (≥1)
- OUT_DIM, 10, output neurons (≥1)
- A_BITWIDTH, 8, activation/weight/bias width (signed)
- OUT_BITWIDTH, 20, MAC output width
- C_BITWIDTH, OUT_BITWIDTH-1, MAC accumulate-operand width
- SHIFT, 8, requantization right shift
- clk  in  1  clock
- rstn  in  1  reset; one clock, asynchronous active-low reset
- start  in  1  start layer (sampled only in IDLE)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after last result write
- x_rd, x_addr  out  1, clog2(IN_DIM)  input buffer read; data returns next cycle
- x_data  in  A_BITWIDTH  input activation
- w_rd, w_addr  out  1, clog2(IN_DIM*OUT_DIM)  weight read, addr = o*IN_DIM+i; data returns next cycle
- w_data  in  A_BITWIDTH  weight
- b_rd, b_addr  out  1, clog2(OUT_DIM)  bias read; data returns next cycle
- b_data  in  A_BITWIDTH  bias
- mac_en, mac_add  out  1 each  MAC control
- mac_a, mac_b  out  A_BITWIDTH  MAC operands
- mac_c  out  C_BITWIDTH  MAC accumulate operand
- mac_done  in  1  MAC completion flag
- mac_out  in  OUT_BITWIDTH  MAC result
- y_valid, y_addr, y_data  out  1, clog2(OUT_DIM), A_BITWIDTH  result write port

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, B_FETCH, B_ISSUE, B_WAIT, WRITE, FIN.
- IDLE + start → FETCH with o=0, i=0, acc=0. start in any other state is ignored.
- FETCH: pulse x_rd and w_rd at (i, o*IN_DIM+i) → ISSUE.
- ISSUE: mac_en=1 for exactly one cycle; mac_a=x_data, mac_b=w_data, mac_c=sat_C(acc), mac_add=0 → WAIT.
- WAIT: on mac_done=1, latch acc=mac_out. If i<IN_DIM-1: i++, → FETCH. Otherwise → B_FETCH.
- B_FETCH: pulse b_rd at o → B_ISSUE. B_ISSUE: mac_en pulse, mac_a=b_data, mac_c=sat_C(acc), mac_add=1. mac_add is held at 1 through B_WAIT, so the MAC computes (bias<<<8)+acc.
- B_WAIT: on mac_done, latch acc → WRITE.
- WRITE: y_valid=1, y_addr=o, y_data=clamp(max(acc,0)>>>SHIFT, 0, 2^(A_BITWIDTH-1)-1). If o<OUT_DIM-1: o++, i=0, acc=0, → FETCH. Otherwise → FIN.
- FIN: done=1 → IDLE.
- sat_C: signed saturation of the OUT_BITWIDTH acc to the C_BITWIDTH range.
- mac_en is never asserted while mac_done=1.

## Timing
- Reset: state IDLE, all counters/acc 0. busy, done, all *_rd, mac_en, mac_add, y_valid = 0. All address and data outputs = 0.
- MAC op: en at cycle t → mac_done at t+3, cleared at t+4. One element costs 5 cycles (FETCH, ISSUE, 3×WAIT).
- Per neuron: 5·IN_DIM + 5 (bias) + 1 (WRITE) cycles. Layer total = OUT_DIM·(5·IN_DIM+6) + 1 (FIN). busy is high for exactly that many cycles.
- Buffer read latency is fixed at 1 cycle. Read data is consumed only in the following ISSUE/B_ISSUE.
- Mid-operation rstn assertion aborts immediately to reset values. No y_valid or done follows; a fresh start is required.
- Boundary IN_DIM=1: FETCH→ISSUE→WAIT→B_FETCH directly. Counter wrap occurs only via explicit compare to DIM-1.

## Structure
- Shared package fc_pkg holds: state encoding localparams, SHIFT default, saturation/clamp width constants, used by all fc blocks.
- One sub-module: fc_requant (combinational ReLU+shift+clamp), reused by other layers.
- The `mac` is instantiated outside, beside this block, so it can be shared.

## Test plan
- IN_DIM=2, OUT_DIM=1, x={3,4}, w={2,5}, b=1 → acc 26, then 282; y_data=1 at y_addr=0; done after 17 busy cycles.
- Same with w={-2,-5} → acc -26+256=230 → y_data=0. Then b=-1 → negative sum → ReLU gives y_data=0.
- x={127,127}, w={127,127}, b=2 → 32770>>>8=128 → clamped y_data=127.
- OUT_DIM=3, random data vs. golden model → three writes, y_addr 0,1,2 in order, w_addr sequence 0..3·IN_DIM-1.
- start pulsed while busy and again in FIN → no restart, single done pulse.
- rstn dropped during neuron 1 WAIT → all outputs 0 next cycle, no y_valid. A restart then produces a full correct layer.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer blocks: sequencer state
// encoding, default widths and the address-width helper.
package fc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_B_FETCH,
        S_B_ISSUE,
        S_B_WAIT,
        S_WRITE,
        S_FIN
    } fc_state_t;

    localparam int SHIFT_DEFAULT        = 8;
    localparam int A_BITWIDTH_DEFAULT   = 8;
    localparam int OUT_BITWIDTH_DEFAULT = 20;

    // A dimension of 1 still needs a 1-bit address bus.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// ReLU, arithmetic right shift and clamp to the positive range of a signed
// OUT_W-bit activation. Purely combinational so any layer can reuse it.
module fc_requant
    import fc_pkg::*;
#(
    parameter int IN_W  = OUT_BITWIDTH_DEFAULT,
    parameter int OUT_W = A_BITWIDTH_DEFAULT,
    parameter int SHIFT = SHIFT_DEFAULT
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic        [OUT_W-1:0] y
);

    localparam logic [IN_W-1:0] Y_MAX = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);

    logic [IN_W-1:0] relu;
    logic [IN_W-1:0] shifted;

    // After ReLU the value is non-negative, so a logical shift is exact.
    always_comb begin
        relu    = acc[IN_W-1] ? '0 : acc;
        shifted = relu >> SHIFT;
        y       = (shifted > Y_MAX) ? Y_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Drives one fully-connected layer through an external shared MAC: one MAC op
// per input/weight pair, one bias op per neuron, then ReLU/requant and a write.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int IN_DIM       = 64,
    parameter int OUT_DIM      = 10,
    parameter int A_BITWIDTH   = A_BITWIDTH_DEFAULT,
    parameter int OUT_BITWIDTH = OUT_BITWIDTH_DEFAULT,
    parameter int C_BITWIDTH   = OUT_BITWIDTH - 1,
    parameter int SHIFT        = SHIFT_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  x_rd,
    output logic [addr_w(IN_DIM)-1:0]             x_addr,
    input  logic [A_BITWIDTH-1:0]                 x_data,
    output logic                                  w_rd,
    output logic [addr_w(IN_DIM*OUT_DIM)-1:0]     w_addr,
    input  logic [A_BITWIDTH-1:0]                 w_data,
    output logic                                  b_rd,
    output logic [addr_w(OUT_DIM)-1:0]            b_addr,
    input  logic [A_BITWIDTH-1:0]                 b_data,
    output logic                                  mac_en,
    output logic                                  mac_add,
    output logic [A_BITWIDTH-1:0]                 mac_a,
    output logic [A_BITWIDTH-1:0]                 mac_b,
    output logic [C_BITWIDTH-1:0]                 mac_c,
    input  logic                                  mac_done,
    input  logic [OUT_BITWIDTH-1:0]               mac_out,
    output logic                                  y_valid,
    output logic [addr_w(OUT_DIM)-1:0]            y_addr,
    output logic [A_BITWIDTH-1:0]                 y_data
);

    localparam int XA_W = addr_w(IN_DIM);
    localparam int WA_W = addr_w(IN_DIM * OUT_DIM);
    localparam int OA_W = addr_w(OUT_DIM);

    localparam logic [XA_W-1:0] I_LAST = XA_W'(IN_DIM - 1);
    localparam logic [OA_W-1:0] O_LAST = OA_W'(OUT_DIM - 1);

    localparam logic signed [OUT_BITWIDTH-1:0] C_MAX =
        OUT_BITWIDTH'((64'd1 << (C_BITWIDTH - 1)) - 64'd1);
    localparam logic signed [OUT_BITWIDTH-1:0] C_MIN = ~C_MAX;

    fc_state_t                       state_reg;
    logic [XA_W-1:0]                 i_reg;
    logic [OA_W-1:0]                 o_reg;
    logic [WA_W-1:0]                 w_idx_reg;
    logic signed [OUT_BITWIDTH-1:0]  acc_reg;
    logic                            busy_reg;
    logic                            done_reg;
    logic                            x_rd_reg;
    logic                            w_rd_reg;
    logic                            b_rd_reg;
    logic                            mac_en_reg;
    logic                            mac_add_reg;
    logic                            y_valid_reg;
    logic [A_BITWIDTH-1:0]           y_data_reg;
    logic [A_BITWIDTH-1:0]           requant_y;
    logic signed [C_BITWIDTH-1:0]    acc_sat;
    logic                            issue_x;
    logic                            issue_b;

    fc_requant #(
        .IN_W  (OUT_BITWIDTH),
        .OUT_W (A_BITWIDTH),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc (mac_out),
        .y   (requant_y)
    );

    always_comb begin
        if (acc_reg > C_MAX) begin
            acc_sat = C_MAX[C_BITWIDTH-1:0];
        end else if (acc_reg < C_MIN) begin
            acc_sat = C_MIN[C_BITWIDTH-1:0];
        end else begin
            acc_sat = acc_reg[C_BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            i_reg       <= '0;
            o_reg       <= '0;
            w_idx_reg   <= '0;
            acc_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            x_rd_reg    <= 1'b0;
            w_rd_reg    <= 1'b0;
            b_rd_reg    <= 1'b0;
            mac_en_reg  <= 1'b0;
            mac_add_reg <= 1'b0;
            y_valid_reg <= 1'b0;
            y_data_reg  <= '0;
        end else begin
            x_rd_reg    <= 1'b0;
            w_rd_reg    <= 1'b0;
            b_rd_reg    <= 1'b0;
            mac_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            y_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_FETCH;
                        busy_reg  <= 1'b1;
                        i_reg     <= '0;
                        o_reg     <= '0;
                        w_idx_reg <= '0;
                        acc_reg   <= '0;
                        x_rd_reg  <= 1'b1;
                        w_rd_reg  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_reg  <= S_ISSUE;
                    mac_en_reg <= 1'b1;
                end
                S_ISSUE: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (mac_done) begin
                        acc_reg <= mac_out;
                        if (i_reg != I_LAST) begin
                            i_reg     <= i_reg + XA_W'(1);
                            w_idx_reg <= w_idx_reg + WA_W'(1);
                            x_rd_reg  <= 1'b1;
                            w_rd_reg  <= 1'b1;
                            state_reg <= S_FETCH;
                        end else begin
                            b_rd_reg  <= 1'b1;
                            state_reg <= S_B_FETCH;
                        end
                    end
                end
                // mac_add stays high until the bias result returns.
                S_B_FETCH: begin
                    state_reg   <= S_B_ISSUE;
                    mac_en_reg  <= 1'b1;
                    mac_add_reg <= 1'b1;
                end
                S_B_ISSUE: state_reg <= S_B_WAIT;
                S_B_WAIT: begin
                    if (mac_done) begin
                        acc_reg     <= mac_out;
                        mac_add_reg <= 1'b0;
                        y_valid_reg <= 1'b1;
                        y_data_reg  <= requant_y;
                        state_reg   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    y_data_reg <= '0;
                    if (o_reg != O_LAST) begin
                        o_reg     <= o_reg + OA_W'(1);
                        i_reg     <= '0;
                        w_idx_reg <= w_idx_reg + WA_W'(1);
                        acc_reg   <= '0;
                        x_rd_reg  <= 1'b1;
                        w_rd_reg  <= 1'b1;
                        state_reg <= S_FETCH;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Buffer data arrives during the issue cycle, so operands are muxed from it.
    assign issue_x = (state_reg == S_ISSUE);
    assign issue_b = (state_reg == S_B_ISSUE);

    assign mac_a   = issue_x ? x_data : (issue_b ? b_data : '0);
    assign mac_b   = issue_x ? w_data : '0;
    assign mac_c   = (issue_x || issue_b) ? acc_sat : '0;
    assign mac_en  = mac_en_reg;
    assign mac_add = mac_add_reg;

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign x_rd    = x_rd_reg;
    assign w_rd    = w_rd_reg;
    assign b_rd    = b_rd_reg;
    assign x_addr  = i_reg;
    assign w_addr  = w_idx_reg;
    assign b_addr  = o_reg;
    assign y_valid = y_valid_reg;
    assign y_addr  = o_reg;
    assign y_data  = y_data_reg;

endmodule
